mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage of the 5-stage MIPS pipeline, directly downstream of Execute.
//  - Owns the E/M pipeline register.
//  - Drives the data bus: address, aligned write data, byte enables.
//  - Detects address exceptions (AdEL/AdES) and merges them with the exception code from Execute.
//  - Sign/zero-extends load data and provides the M-stage forwarding value and Tnew to hazard control.
// PARAMETERS
//  DM_END      32'h0000_3000  exclusive upper bound of data memory (base 0)
//  TMR0_BASE   32'h0000_7F00  timer0 window, 12 bytes
//  TMR1_BASE   32'h0000_7F10  timer1 window, 12 bytes
//  IG_BASE     32'h0000_7F20  interrupt generator, 4 bytes
//  HANDLER_PC  32'h0000_4180  PC loaded into the bubble on req
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high
//  req          in   1   CP0 exception/interrupt flush request
//  E_PC         in   32  PC of instruction in E
//  E_ins        in   32  instruction in E
//  E_alu_res    in   32  ALU result (memory address for ld/st)
//  E_mlu_res    in   32  HI/LO read result
//  E_reg_rt     in   32  forwarded rt value (store data)
//  E_reg_write  in   32  E-produced writeback value (imm / PC+8)
//  E_regw_adr   in   5   destination register, 0 = none
//  E_T          in   5   Tnew in E
//  E_exc        in   5   accumulated exception code from F/D/E, 0 = none
//  E_bd         in   1   instruction is in a branch delay slot
//  m_rdata      in   32  bus read data (combinational, same cycle)
//  M_PC         out  32  registered PC
//  M_ins        out  32  registered instruction
//  m_addr       out  32  bus address = registered ALU result
//  m_wdata      out  32  lane-aligned store data
//  m_byteen     out  4   byte write enables
//  load_res     out  32  extended load data
//  fwd_val      out  32  M-stage forwarding value
//  regw_adr     out  5   registered destination
//  T            out  5   Tnew in M
//  exc_code     out  5   final exception code
//  bd           out  1   registered branch-delay flag
// BEHAVIOUR
//  - Register update, every posedge:
//    - reset=1: all fields cleared (PC=0, ins=0 i.e. nop, exc=0, bd=0, T=0). reset dominates req.
//    - else req=1: bubble, identical to reset except PC=HANDLER_PC.
//    - else: latch all E_* fields. No stall input; M never holds.
//  - T = (E_T>0) ? E_T-1 : 0, saturating, computed at latch time.
//  - Decode (from M_ins), exactly one class:
//    - loads: lw, lh, lhu, lb, lbu
//    - stores: sw, sh, sb
//    - wb_src: ALU, MLU, E-value, or LOAD
//  - fwd_val by wb_src: ALU -> alu, MLU -> mlu, E-value -> reg_write; LOAD -> 0 (T stays >0, so hazard control stalls).
//  - Exception check, only when latched exc==0 and instruction is ld/st; first match wins:
//    1. misaligned: lw/sw addr[1:0]!=0; lh/lhu/sh addr[0]!=0
//    2. half/byte access to any timer window
//    3. address outside DM, both timer windows, and IG
//    4. store to timer count register (TMRx_BASE+8)
//    - any match: code 4 (AdEL) for loads, 5 (AdES) for stores
//  - exc_code = latched exc ? latched exc : detected code. Earlier stages win.
//  - Store lanes:
//    - sw: byteen 1111, wdata = rt
//    - sh: byteen 0011<<(2*addr[1]), wdata = rt[15:0]<<(16*addr[1])
//    - sb: byteen 0001<<addr[1:0], wdata = rt[7:0]<<(8*addr[1:0])
//  - m_byteen forced to 0 when exc_code!=0 or req=1 in the same cycle, so no side effects.
//  - Load extension selects the lane by addr[1:0]:
//    - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through
//    - non-loads drive load_res=0
//  - Reset mid-operation: a store in M during the reset cycle has byteen 0 only if req=1. Reset alone does not mask the bus (bus is reset by its own owner).
// STRUCTURE
//  - Shared in macros.v: opcode/funct constants, EXC_ADEL=4, EXC_ADES=5, address-map constants.
//  - One sub-module: mem_ext. Combinational load extension from (addr[1:0], load type, m_rdata).
//  - Everything else inline: pipeline register, decode, exception check, store lanes.
// TESTING
//  1. sb, rt=0x000000AB, addr=0x0000_0003 -> byteen 1000, wdata 0xAB000000, exc 0.
//  2. lh, addr=0x0000_0002, rdata=0x8001_1234 -> load_res 0xFFFF8001.
//     Same with lhu -> 0x00008001.
//  3. lw, addr=0x0000_0006 -> exc 4, byteen 0.
//     sw to 0x0000_7F08 -> exc 5, byteen 0.
//     sh to 0x0000_7F00 -> exc 5.
//  4. E_exc=12 (Ov) on sw to misaligned address -> exc 12 (not 5), byteen 0.
//  5. req=1 while lw latches -> next cycle M_PC 0x00004180, M_ins 0, T 0.
//     reset=1 together with req -> M_PC 0.
//  6. lw with E_T=2 -> T=1, fwd_val 0.
//     addu with E_T=1 -> T=0, fwd_val = E_alu_res.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//  Shared definitions for the memory stage: the address map, the exception
//  codes, the MIPS opcode/funct values the stage decodes, the small
//  enumerations used internally, and a window-membership helper.
//  This file has no ports.
package mem_stage_pkg;

    // Address map
    localparam logic [31:0] MEM_DM_END     = 32'h0000_3000;
    localparam logic [31:0] MEM_TMR0_BASE  = 32'h0000_7F00;
    localparam logic [31:0] MEM_TMR1_BASE  = 32'h0000_7F10;
    localparam logic [31:0] MEM_IG_BASE    = 32'h0000_7F20;
    localparam logic [31:0] MEM_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] TMR_WIN_SIZE   = 32'd12;
    localparam logic [31:0] IG_WIN_SIZE    = 32'd4;
    localparam logic [31:0] TMR_CNT_OFS    = 32'd8;

    // Exception codes
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct values that do not take the ALU result
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_W    = 3'd1,
        LD_H    = 3'd2,
        LD_HU   = 3'd3,
        LD_B    = 3'd4,
        LD_BU   = 3'd5
    } ld_type_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_W    = 2'd1,
        ST_H    = 2'd2,
        ST_B    = 2'd3
    } st_type_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MLU  = 2'd1,
        WB_EVAL = 2'd2,
        WB_LOAD = 2'd3
    } wb_src_e;

    // True when addr lies in [base, base+size). Windows sit far below 2^32,
    // so base+size cannot wrap.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr >= base) && (addr < (base + size));
    endfunction

endpackage

// File: rtl/mem_stage_ext.sv
// mem_ext
//  Combinational load extension. Selects the byte/half lane addressed by
//  the low address bits and sign- or zero-extends it to 32 bits.
//  Ports:
//   addr_lo_i   in  2   low address bits (lane select)
//   ld_type_i   in  3   load type (ld_type_e encoding), LD_NONE -> 0
//   rdata_i     in  32  raw bus read data
//   load_res_o  out 32  extended load value
module mem_ext
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  ld_type_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] load_res_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase

        case (ld_type_i)
            LD_W:    load_res_o = rdata_i;
            LD_H:    load_res_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_res_o = {16'h0000, half_sel};
            LD_B:    load_res_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   load_res_o = {24'h00_0000, byte_sel};
            default: load_res_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//  Memory stage of the 5-stage MIPS pipeline. Holds the E/M pipeline
//  register, drives the data bus (address, lane-aligned write data, byte
//  enables), detects AdEL/AdES and merges them with the upstream exception
//  code, extends load data, and supplies the M-stage forwarding value and
//  Tnew to hazard control.
//  Ports:
//   clk, reset   clock (rising edge), synchronous active-high reset
//   req          CP0 flush request; turns the latched slot into a bubble
//   E_*          fields of the instruction leaving Execute
//   m_rdata      combinational bus read data
//   M_PC, M_ins  registered PC / instruction
//   m_addr       bus address (registered ALU result)
//   m_wdata      lane-aligned store data
//   m_byteen     byte write enables, zero on any exception or flush
//   load_res     extended load data
//   fwd_val      forwarding value (0 for loads)
//   regw_adr     registered destination register
//   T            Tnew in M
//   exc_code     final exception code
//   bd           registered branch-delay flag
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] DM_END     = MEM_DM_END,
    parameter logic [31:0] TMR0_BASE  = MEM_TMR0_BASE,
    parameter logic [31:0] TMR1_BASE  = MEM_TMR1_BASE,
    parameter logic [31:0] IG_BASE    = MEM_IG_BASE,
    parameter logic [31:0] HANDLER_PC = MEM_HANDLER_PC
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_ins,
    input  logic [31:0] E_alu_res,
    input  logic [31:0] E_mlu_res,
    input  logic [31:0] E_reg_rt,
    input  logic [31:0] E_reg_write,
    input  logic [4:0]  E_regw_adr,
    input  logic [4:0]  E_T,
    input  logic [4:0]  E_exc,
    input  logic        E_bd,
    input  logic [31:0] m_rdata,
    output logic [31:0] M_PC,
    output logic [31:0] M_ins,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byteen,
    output logic [31:0] load_res,
    output logic [31:0] fwd_val,
    output logic [4:0]  regw_adr,
    output logic [4:0]  T,
    output logic [4:0]  exc_code,
    output logic        bd
);

    logic [31:0] pc_q, ins_q, alu_q, mlu_q, rt_q, rw_q;
    logic [4:0]  adr_q, t_q, exc_q;
    logic        bd_q;
    logic [4:0]  t_d;

    // Tnew counts down by one per stage and saturates at zero.
    always_comb begin
        t_d = (E_T != 5'd0) ? (E_T - 5'd1) : 5'd0;
    end

    // A flush produces the same bubble as reset, except that its PC points
    // at the handler so CP0 sees a sensible EPC source.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= 32'h0;
            ins_q <= 32'h0;
            alu_q <= 32'h0;
            mlu_q <= 32'h0;
            rt_q  <= 32'h0;
            rw_q  <= 32'h0;
            adr_q <= 5'd0;
            t_q   <= 5'd0;
            exc_q <= EXC_NONE;
            bd_q  <= 1'b0;
        end else if (req) begin
            pc_q  <= HANDLER_PC;
            ins_q <= 32'h0;
            alu_q <= 32'h0;
            mlu_q <= 32'h0;
            rt_q  <= 32'h0;
            rw_q  <= 32'h0;
            adr_q <= 5'd0;
            t_q   <= 5'd0;
            exc_q <= EXC_NONE;
            bd_q  <= 1'b0;
        end else begin
            pc_q  <= E_PC;
            ins_q <= E_ins;
            alu_q <= E_alu_res;
            mlu_q <= E_mlu_res;
            rt_q  <= E_reg_rt;
            rw_q  <= E_reg_write;
            adr_q <= E_regw_adr;
            t_q   <= t_d;
            exc_q <= E_exc;
            bd_q  <= E_bd;
        end
    end

    // Decode
    logic [5:0] opcode, funct;
    ld_type_e   ld_type;
    st_type_e   st_type;
    wb_src_e    wb_src;

    always_comb begin
        opcode  = ins_q[31:26];
        funct   = ins_q[5:0];
        ld_type = LD_NONE;
        st_type = ST_NONE;
        wb_src  = WB_ALU;
        case (opcode)
            OP_LW:  begin ld_type = LD_W;  wb_src = WB_LOAD; end
            OP_LH:  begin ld_type = LD_H;  wb_src = WB_LOAD; end
            OP_LHU: begin ld_type = LD_HU; wb_src = WB_LOAD; end
            OP_LB:  begin ld_type = LD_B;  wb_src = WB_LOAD; end
            OP_LBU: begin ld_type = LD_BU; wb_src = WB_LOAD; end
            OP_SW:  st_type = ST_W;
            OP_SH:  st_type = ST_H;
            OP_SB:  st_type = ST_B;
            OP_JAL, OP_LUI: wb_src = WB_EVAL;
            OP_SPECIAL: begin
                if (funct == FN_MFHI || funct == FN_MFLO) begin
                    wb_src = WB_MLU;
                end else if (funct == FN_JALR) begin
                    wb_src = WB_EVAL;
                end
            end
            default: wb_src = WB_ALU;
        endcase
    end

    // Address exception check. The rules are listed in priority order, but
    // every rule maps to the same code for a given access direction, so a
    // plain OR of the conditions gives the same result.
    logic is_load, is_store, is_word, is_half, is_sub;
    logic in_tmr, in_ig, in_dm;
    logic misal, sub_tmr, unmapped, st_cnt;
    logic [4:0] det_code;

    always_comb begin
        is_load  = (ld_type != LD_NONE);
        is_store = (st_type != ST_NONE);
        is_word  = (ld_type == LD_W) || (st_type == ST_W);
        is_half  = (ld_type == LD_H) || (ld_type == LD_HU) || (st_type == ST_H);
        is_sub   = (is_load || is_store) && !is_word;

        in_tmr = in_window(alu_q, TMR0_BASE, TMR_WIN_SIZE)
              || in_window(alu_q, TMR1_BASE, TMR_WIN_SIZE);
        in_ig  = in_window(alu_q, IG_BASE, IG_WIN_SIZE);
        in_dm  = (alu_q < DM_END);

        misal    = (is_word && (alu_q[1:0] != 2'b00)) || (is_half && alu_q[0]);
        sub_tmr  = is_sub && in_tmr;
        unmapped = !(in_dm || in_tmr || in_ig);
        st_cnt   = is_store && ((alu_q == (TMR0_BASE + TMR_CNT_OFS))
                             || (alu_q == (TMR1_BASE + TMR_CNT_OFS)));

        det_code = EXC_NONE;
        if ((exc_q == EXC_NONE) && (is_load || is_store)
            && (misal || sub_tmr || unmapped || st_cnt)) begin
            det_code = is_load ? EXC_ADEL : EXC_ADES;
        end

        // Earlier stages take precedence over anything detected here.
        exc_code = (exc_q != EXC_NONE) ? exc_q : det_code;
    end

    // Store lanes. Byte enables are suppressed on any exception and on a
    // flush in the same cycle; reset alone leaves the bus to its owner.
    always_comb begin
        m_byteen = 4'b0000;
        m_wdata  = 32'h0;
        case (st_type)
            ST_W: begin
                m_byteen = 4'b1111;
                m_wdata  = rt_q;
            end
            ST_H: begin
                m_byteen = 4'b0011 << {alu_q[1], 1'b0};
                m_wdata  = {16'h0000, rt_q[15:0]} << {alu_q[1], 4'b0000};
            end
            ST_B: begin
                m_byteen = 4'b0001 << alu_q[1:0];
                m_wdata  = {24'h00_0000, rt_q[7:0]} << {alu_q[1:0], 3'b000};
            end
            default: begin
                m_byteen = 4'b0000;
                m_wdata  = 32'h0;
            end
        endcase
        if ((exc_code != EXC_NONE) || req) begin
            m_byteen = 4'b0000;
        end
    end

    mem_ext u_mem_ext (
        .addr_lo_i  (alu_q[1:0]),
        .ld_type_i  (ld_type),
        .rdata_i    (m_rdata),
        .load_res_o (load_res)
    );

    // Load data is not ready for forwarding in M; Tnew stays nonzero so
    // hazard control stalls instead of consuming this zero.
    always_comb begin
        case (wb_src)
            WB_MLU:  fwd_val = mlu_q;
            WB_EVAL: fwd_val = rw_q;
            WB_LOAD: fwd_val = 32'h0;
            default: fwd_val = alu_q;
        endcase
    end

    assign M_PC     = pc_q;
    assign M_ins    = ins_q;
    assign m_addr   = alu_q;
    assign regw_adr = adr_q;
    assign T        = t_q;
    assign bd       = bd_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset, req;
    logic [31:0] E_PC, E_ins, E_alu_res, E_mlu_res, E_reg_rt, E_reg_write;
    logic [4:0]  E_regw_adr, E_T, E_exc;
    logic        E_bd;
    logic [31:0] m_rdata;
    logic [31:0] M_PC, M_ins, m_addr, m_wdata, load_res, fwd_val;
    logic [3:0]  m_byteen;
    logic [4:0]  regw_adr, T, exc_code;
    logic        bd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .req(req),
        .E_PC(E_PC), .E_ins(E_ins), .E_alu_res(E_alu_res), .E_mlu_res(E_mlu_res),
        .E_reg_rt(E_reg_rt), .E_reg_write(E_reg_write), .E_regw_adr(E_regw_adr),
        .E_T(E_T), .E_exc(E_exc), .E_bd(E_bd), .m_rdata(m_rdata),
        .M_PC(M_PC), .M_ins(M_ins), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_byteen(m_byteen), .load_res(load_res), .fwd_val(fwd_val),
        .regw_adr(regw_adr), .T(T), .exc_code(exc_code), .bd(bd)
    );

    // Instruction kinds, at mnemonic level
    localparam int K_NOP = 0, K_LW = 1, K_LH = 2, K_LHU = 3, K_LB = 4, K_LBU = 5,
                   K_SW = 6, K_SH = 7, K_SB = 8, K_ADDU = 9, K_ORI = 10,
                   K_MFHI = 11, K_MFLO = 12, K_JAL = 13, K_JALR = 14, K_LUI = 15;
    localparam int NK = 16;

    function automatic logic [31:0] enc(input int k);
        logic [31:0] r;
        logic [5:0]  op;
        logic [5:0]  fn;
        r  = $urandom;
        op = 6'h00;
        fn = 6'h00;
        case (k)
            K_LW: op = 6'h23;  K_LH: op = 6'h21;  K_LHU: op = 6'h25;
            K_LB: op = 6'h20;  K_LBU: op = 6'h24; K_SW: op = 6'h2B;
            K_SH: op = 6'h29;  K_SB: op = 6'h28;  K_ORI: op = 6'h0D;
            K_JAL: op = 6'h03; K_LUI: op = 6'h0F;
            K_ADDU: fn = 6'h21; K_MFHI: fn = 6'h10; K_MFLO: fn = 6'h12;
            K_JALR: fn = 6'h09;
            default: ;
        endcase
        if (k == K_NOP) return 32'h0;
        if (op == 6'h00) return {6'h00, r[25:11], 5'd0, fn};
        return {op, r[25:0]};
    endfunction

    function automatic bit is_ld(input int k);
        return k == K_LW || k == K_LH || k == K_LHU || k == K_LB || k == K_LBU;
    endfunction
    function automatic bit is_st(input int k);
        return k == K_SW || k == K_SH || k == K_SB;
    endfunction
    function automatic int acc_size(input int k);
        if (k == K_LW || k == K_SW) return 4;
        if (k == K_LH || k == K_LHU || k == K_SH) return 2;
        return 1;
    endfunction

    // Expected combinational outputs of an instruction sitting in M
    function automatic void model_out(
        input int k, input logic [31:0] a, input logic [31:0] rt,
        input logic [31:0] rdata, input logic [31:0] alu, input logic [31:0] mlu,
        input logic [31:0] rw, input logic [4:0] exc, input bit req_now,
        output logic [3:0] be, output logic [31:0] wd, output logic [31:0] ld,
        output logic [31:0] fwd, output logic [4:0] ec);
        int sz, o;
        bit in_tmr, in_ig, in_dm, bad;
        logic [31:0] mask, v;
        sz = acc_size(k);
        o  = (sz == 4) ? 0 : (sz == 2) ? int'(a & 32'h2) : int'(a & 32'h3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        in_tmr = (a >= 32'h7F00 && a < 32'h7F0C) || (a >= 32'h7F10 && a < 32'h7F1C);
        in_ig  = (a >= 32'h7F20 && a < 32'h7F24);
        in_dm  = (a < 32'h3000);
        bad = ((a % sz) != 0) || (sz < 4 && in_tmr) || !(in_dm || in_tmr || in_ig)
              || (is_st(k) && (a == 32'h7F08 || a == 32'h7F18));
        if (exc != 0) ec = exc;
        else if ((is_ld(k) || is_st(k)) && bad) ec = is_ld(k) ? 5'd4 : 5'd5;
        else ec = 5'd0;
        be = 4'b0000;
        wd = 32'h0;
        if (is_st(k)) begin
            be = 4'(((1 << sz) - 1) << o);
            wd = (rt & mask) << (8 * o);
            if (ec != 0 || req_now) be = 4'b0000;
        end
        ld = 32'h0;
        if (is_ld(k)) begin
            v = (rdata >> (8 * o)) & mask;
            if ((k == K_LH || k == K_LB) && v[8 * sz - 1]) v = v | ~mask;
            ld = v;
        end
        if (is_ld(k)) fwd = 32'h0;
        else if (k == K_MFHI || k == K_MFLO) fwd = mlu;
        else if (k == K_JAL || k == K_JALR || k == K_LUI) fwd = rw;
        else fwd = alu;
    endfunction

    task automatic set_e(input int k, input logic [31:0] a, input logic [31:0] rt,
                         input logic [4:0] t, input logic [4:0] exc);
        E_PC        = $urandom & 32'hFFFF_FFFC;
        E_ins       = enc(k);
        E_alu_res   = a;
        E_mlu_res   = $urandom;
        E_reg_rt    = rt;
        E_reg_write = $urandom;
        E_regw_adr  = 5'($urandom);
        E_T         = t;
        E_exc       = exc;
        E_bd        = 1'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; m_rdata = 32'h0;
        set_e(K_SW, 32'h10, 32'h1234_5678, 5'd3, 5'd0);
        step(); step();
        reset = 1'b0;
        checks++; if (M_PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", M_PC, 32'h0); end
        checks++; if (M_ins !== 32'h0) begin errors++; $display("FAIL reset_ins got %h want %h", M_ins, 32'h0); end
        checks++; if (T !== 5'd0) begin errors++; $display("FAIL reset_T got %0d want 0", T); end
        checks++; if (exc_code !== 5'd0 || bd !== 1'b0) begin errors++; $display("FAIL reset_exc_bd got %0d/%b want 0/0", exc_code, bd); end
        checks++; if (m_byteen !== 4'b0000) begin errors++; $display("FAIL reset_byteen got %b want 0000", m_byteen); end
    endtask

    task automatic test_store_lanes();
        set_e(K_SB, 32'h3, 32'h0000_00AB, 5'd0, 5'd0);
        step();
        checks++; if (m_byteen !== 4'b1000) begin errors++; $display("FAIL sb_byteen got %b want 1000", m_byteen); end
        checks++; if (m_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL sb_wdata got %h want AB000000", m_wdata); end
        checks++; if (exc_code !== 5'd0) begin errors++; $display("FAIL sb_exc got %0d want 0", exc_code); end
        set_e(K_SH, 32'h102, 32'hDEAD_BEEF, 5'd0, 5'd0);
        step();
        checks++; if (m_byteen !== 4'b1100 || m_wdata !== 32'hBEEF_0000) begin errors++; $display("FAIL sh_lane got %b/%h want 1100/BEEF0000", m_byteen, m_wdata); end
    endtask

    task automatic test_load_ext();
        set_e(K_LH, 32'h2, 32'h0, 5'd2, 5'd0);
        step();
        m_rdata = 32'h8001_1234; #1;
        checks++; if (load_res !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_ext got %h want FFFF8001", load_res); end
        set_e(K_LHU, 32'h2, 32'h0, 5'd2, 5'd0);
        step();
        checks++; if (load_res !== 32'h0000_8001) begin errors++; $display("FAIL lhu_ext got %h want 00008001", load_res); end
        set_e(K_LB, 32'h1, 32'h0, 5'd2, 5'd0);
        step();
        m_rdata = 32'h0000_9000; #1;
        checks++; if (load_res !== 32'hFFFF_FF90) begin errors++; $display("FAIL lb_ext got %h want FFFFFF90", load_res); end
    endtask

    task automatic test_addr_exc();
        set_e(K_LW, 32'h6, 32'h0, 5'd2, 5'd0);
        step();
        checks++; if (exc_code !== 5'd4 || m_byteen !== 4'b0000) begin errors++; $display("FAIL lw_misal got %0d/%b want 4/0000", exc_code, m_byteen); end
        set_e(K_SW, 32'h7F08, 32'h5, 5'd0, 5'd0);
        step();
        checks++; if (exc_code !== 5'd5 || m_byteen !== 4'b0000) begin errors++; $display("FAIL sw_tmrcnt got %0d/%b want 5/0000", exc_code, m_byteen); end
        set_e(K_SH, 32'h7F00, 32'h5, 5'd0, 5'd0);
        step();
        checks++; if (exc_code !== 5'd5) begin errors++; $display("FAIL sh_tmr got %0d want 5", exc_code); end
        set_e(K_LW, 32'h7F24, 32'h0, 5'd2, 5'd0);
        step();
        checks++; if (exc_code !== 5'd4) begin errors++; $display("FAIL lw_unmapped got %0d want 4", exc_code); end
        set_e(K_SW, 32'h7F20, 32'h1, 5'd0, 5'd0);
        step();
        checks++; if (exc_code !== 5'd0 || m_byteen !== 4'b1111) begin errors++; $display("FAIL sw_ig got %0d/%b want 0/1111", exc_code, m_byteen); end
        set_e(K_LW, 32'h2FFC, 32'h0, 5'd2, 5'd0);
        step();
        checks++; if (exc_code !== 5'd0) begin errors++; $display("FAIL lw_dm_top got %0d want 0", exc_code); end
    endtask

    task automatic test_exc_priority();
        set_e(K_SW, 32'h1, 32'h5, 5'd0, 5'd12);
        step();
        checks++; if (exc_code !== 5'd12 || m_byteen !== 4'b0000) begin errors++; $display("FAIL upstream_exc got %0d/%b want 12/0000", exc_code, m_byteen); end
    endtask

    task automatic test_flush();
        set_e(K_LW, 32'h20, 32'h0, 5'd2, 5'd0);
        req = 1'b1;
        step();
        req = 1'b0;
        checks++; if (M_PC !== 32'h4180 || M_ins !== 32'h0 || T !== 5'd0) begin errors++; $display("FAIL req_bubble got %h/%h/%0d want 00004180/0/0", M_PC, M_ins, T); end
        set_e(K_LW, 32'h20, 32'h0, 5'd2, 5'd0);
        req = 1'b1; reset = 1'b1;
        step();
        req = 1'b0; reset = 1'b0;
        checks++; if (M_PC !== 32'h0) begin errors++; $display("FAIL reset_over_req got %h want 0", M_PC); end
        set_e(K_SW, 32'h10, 32'h7, 5'd0, 5'd0);
        step();
        reset = 1'b1; #1;
        checks++; if (m_byteen !== 4'b1111) begin errors++; $display("FAIL reset_no_mask got %b want 1111", m_byteen); end
        reset = 1'b0; req = 1'b1; #1;
        checks++; if (m_byteen !== 4'b0000) begin errors++; $display("FAIL req_mask got %b want 0000", m_byteen); end
        req = 1'b0;
    endtask

    task automatic test_tnew_fwd();
        set_e(K_LW, 32'h40, 32'h0, 5'd2, 5'd0);
        step();
        checks++; if (T !== 5'd1 || fwd_val !== 32'h0) begin errors++; $display("FAIL lw_T_fwd got %0d/%h want 1/0", T, fwd_val); end
        set_e(K_ADDU, 32'hCAFE_0001, 32'h0, 5'd1, 5'd0);
        step();
        checks++; if (T !== 5'd0 || fwd_val !== 32'hCAFE_0001) begin errors++; $display("FAIL addu_T_fwd got %0d/%h want 0/CAFE0001", T, fwd_val); end
    endtask

    task automatic test_random(input int n);
        int k, mk;
        logic [31:0] a, rt, mpc, mins, malu, mmlu, mrt, mrw;
        logic [4:0]  ex, t, madr, mt, mexc;
        logic        mbd;
        bit          rst_l, req_l, req_o;
        logic [3:0]  xbe;
        logic [31:0] xwd, xld, xfwd, rd;
        logic [4:0]  xec;
        for (int i = 0; i < n; i++) begin
            k = int'($urandom_range(0, NK - 1));
            case ($urandom_range(0, 5))
                0, 1: a = $urandom_range(0, 32'h2FFF);
                2:    a = 32'h7F00 + $urandom_range(0, 15);
                3:    a = 32'h7F10 + $urandom_range(0, 15);
                4:    a = 32'h7F1C + $urandom_range(0, 11);
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            rt = $urandom;
            t  = 5'($urandom_range(0, 4));
            ex = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            rst_l = ($urandom_range(0, 29) == 0);
            req_l = ($urandom_range(0, 9) == 0);
            req_o = ($urandom_range(0, 7) == 0);
            set_e(k, a, rt, t, ex);
            reset = rst_l; req = req_l;
            @(posedge clk);
            if (rst_l || req_l) begin
                mk = K_NOP; mpc = rst_l ? 32'h0 : 32'h4180; mins = 32'h0;
                malu = 0; mmlu = 0; mrt = 0; mrw = 0; madr = 0; mt = 0; mexc = 0; mbd = 0;
            end else begin
                mk = k; mpc = E_PC; mins = E_ins; malu = a; mmlu = E_mlu_res; mrt = rt;
                mrw = E_reg_write; madr = E_regw_adr; mt = (t > 0) ? t - 5'd1 : 5'd0;
                mexc = ex; mbd = E_bd;
            end
            #1;
            reset = 1'b0; req = req_o;
            rd = $urandom; m_rdata = rd;
            #1;
            model_out(mk, malu, mrt, rd, malu, mmlu, mrw, mexc, req_o, xbe, xwd, xld, xfwd, xec);
            checks++; if (M_PC !== mpc || M_ins !== mins || m_addr !== malu) begin errors++; $display("FAIL rnd_regs it %0d got %h/%h/%h want %h/%h/%h", i, M_PC, M_ins, m_addr, mpc, mins, malu); end
            checks++; if (regw_adr !== madr || T !== mt || bd !== mbd) begin errors++; $display("FAIL rnd_fields it %0d got %0d/%0d/%b want %0d/%0d/%b", i, regw_adr, T, bd, madr, mt, mbd); end
            checks++; if (exc_code !== xec) begin errors++; $display("FAIL rnd_exc it %0d kind %0d addr %h got %0d want %0d", i, mk, malu, exc_code, xec); end
            checks++; if (m_byteen !== xbe) begin errors++; $display("FAIL rnd_byteen it %0d kind %0d addr %h got %b want %b", i, mk, malu, m_byteen, xbe); end
            if (is_st(mk)) begin
                checks++; if (m_wdata !== xwd) begin errors++; $display("FAIL rnd_wdata it %0d got %h want %h", i, m_wdata, xwd); end
            end
            checks++; if (load_res !== xld) begin errors++; $display("FAIL rnd_load it %0d kind %0d got %h want %h", i, mk, load_res, xld); end
            checks++; if (fwd_val !== xfwd) begin errors++; $display("FAIL rnd_fwd it %0d kind %0d got %h want %h", i, mk, fwd_val, xfwd); end
            req = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; m_rdata = 32'h0;
        set_e(K_NOP, 32'h0, 32'h0, 5'd0, 5'd0);
        test_reset();
        test_store_lanes();
        test_load_ext();
        test_addr_exc();
        test_exc_priority();
        test_flush();
        test_tnew_fwd();
        test_random(600);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
